// File: rtl/d_cache_responder_pkg.sv
// Shared types and default geometry for the data-cache responder.
// Address split is {tag, index, offset}; tag width derived by tag_width().
package d_cache_responder_pkg;

    localparam int DEF_INDEX_WIDTH        = 5;
    localparam int DEF_BLOCK_OFFSET_WIDTH = 2;
    localparam int DEF_ADDR_WIDTH         = 26;
    localparam int DEF_DATA_WIDTH         = 32;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_action_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_FILL = 2'd2,
        WR      = 2'd3
    } dcr_state_t;

    function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

endpackage

// File: rtl/d_cache_responder_wbuf.sv
// One-entry write buffer: push completes a store immediately, drains via mem_wr_* in the background.
// Push only when empty; entry held stable until mem_wr_ready; used under D_CACHE_RESPONDER_WRITE_BUFFER_EN.
module d_cache_responder_wbuf #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push_vld,
    input  logic [ADDR_WIDTH-1:0] i_push_addr,
    input  logic [DATA_WIDTH-1:0] i_push_dat,
    input  logic                  i_mem_wr_rdy,
    output logic                  o_full,
    output logic                  o_mem_wr_vld,
    output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wr_dat
);

    logic                  r_full;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_dat  <= '0;
        end else if (i_push_vld && !r_full) begin
            r_full <= 1'b1;
            r_addr <= i_push_addr;
            r_dat  <= i_push_dat;
        end else if (r_full && i_mem_wr_rdy) begin
            r_full <= 1'b0;
        end
    end

    assign o_full        = r_full;
    assign o_mem_wr_vld  = r_full;
    assign o_mem_wr_addr = r_full ? r_addr : '0;
    assign o_mem_wr_dat  = r_full ? r_dat  : '0;

endmodule

// File: rtl/d_cache_responder.sv
// Direct-mapped write-through no-allocate D-cache responder; hits answer combinationally, one 4-beat refill at a time.
// out_valid=0 stalls the requester; D_CACHE_RESPONDER_WRITE_BUFFER_EN adds a one-entry background write buffer.
module d_cache_responder
    import d_cache_responder_pkg::*;
#(
    parameter int INDEX_WIDTH        = DEF_INDEX_WIDTH,
    parameter int BLOCK_OFFSET_WIDTH = DEF_BLOCK_OFFSET_WIDTH,
    parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    input  logic                                   req_mem_action,
    input  logic [ADDR_WIDTH-1:0]                  req_addr,
    input  logic [DATA_WIDTH-1:0]                  req_data,
    output logic                                   out_valid,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic                                   mem_rd_req_valid,
    input  logic                                   mem_rd_req_ready,
    output logic [ADDR_WIDTH-BLOCK_OFFSET_WIDTH-1:0] mem_rd_req_addr,
    input  logic                                   mem_rd_resp_valid,
    input  logic [DATA_WIDTH-1:0]                  mem_rd_resp_data,
    output logic                                   mem_wr_valid,
    input  logic                                   mem_wr_ready,
    output logic [ADDR_WIDTH-1:0]                  mem_wr_addr,
    output logic [DATA_WIDTH-1:0]                  mem_wr_data
);

    localparam int TAG_WIDTH = tag_width(ADDR_WIDTH, INDEX_WIDTH, BLOCK_OFFSET_WIDTH);
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << BLOCK_OFFSET_WIDTH;
    localparam int LINE_W    = ADDR_WIDTH - BLOCK_OFFSET_WIDTH;

    logic [LINES-1:0]              r_valid;
    logic [TAG_WIDTH-1:0]          r_tag  [LINES];
    logic [DATA_WIDTH-1:0]         r_data [LINES][WORDS];
    dcr_state_t                    r_state;
    dcr_state_t                    w_state_nxt;
    logic [BLOCK_OFFSET_WIDTH-1:0] r_cnt;
    logic [LINE_W-1:0]             r_line;

    logic [TAG_WIDTH-1:0]          w_req_tag;
    logic [INDEX_WIDTH-1:0]        w_req_idx;
    logic [BLOCK_OFFSET_WIDTH-1:0] w_req_off;
    logic [INDEX_WIDTH-1:0]        w_fill_idx;
    logic [TAG_WIDTH-1:0]          w_fill_tag;
    logic                          w_hit;
    logic                          w_is_read;
    logic                          w_last_beat;
    logic                          w_wb_full;
    logic                          w_out_vld;
    logic                          w_rd_req_vld;
    logic                          w_wr_vld;
    logic                          w_fill_we;
    logic                          w_upd_we;
    logic                          w_latch;
    logic                          w_push;

    assign w_req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign w_req_idx   = req_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_req_off   = req_addr[BLOCK_OFFSET_WIDTH-1:0];
    assign w_fill_idx  = r_line[INDEX_WIDTH-1:0];
    assign w_fill_tag  = r_line[LINE_W-1 -: TAG_WIDTH];
    assign w_hit       = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_is_read   = (mem_action_t'(req_mem_action) == READ);
    assign w_last_beat = &r_cnt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (req_valid) begin
                // A read miss must not overtake a buffered store still heading to memory.
                if (w_is_read) begin
                    if (!w_hit && !w_wb_full) w_state_nxt = RD_REQ;
                end
`ifndef D_CACHE_RESPONDER_WRITE_BUFFER_EN
                else begin
                    w_state_nxt = WR;
                end
`endif
            end
            RD_REQ:  if (mem_rd_req_ready) w_state_nxt = RD_FILL;
            RD_FILL: if (mem_rd_resp_valid && w_last_beat) w_state_nxt = IDLE;
            WR:      if (mem_wr_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_out_vld    = 1'b0;
        w_rd_req_vld = 1'b0;
        w_wr_vld     = 1'b0;
        w_fill_we    = 1'b0;
        w_upd_we     = 1'b0;
        w_latch      = 1'b0;
        w_push       = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: if (req_valid) begin
                    if (w_is_read) begin
                        w_out_vld = w_hit;
                        w_latch   = !w_hit && !w_wb_full;
                    end
`ifdef D_CACHE_RESPONDER_WRITE_BUFFER_EN
                    else if (!w_wb_full) begin
                        w_out_vld = 1'b1;
                        w_push    = 1'b1;
                        w_upd_we  = w_hit;
                    end
`endif
                end
                RD_REQ:  w_rd_req_vld = 1'b1;
                RD_FILL: w_fill_we = mem_rd_resp_valid;
                WR: begin
                    w_wr_vld = 1'b1;
                    if (mem_wr_ready) begin
                        w_out_vld = 1'b1;
                        w_upd_we  = w_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_cnt   <= '0;
            r_line  <= '0;
        end else begin
            if (w_latch) r_line <= req_addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH];
            if (r_state == RD_REQ && mem_rd_req_ready) r_cnt <= '0;
            if (w_fill_we) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_last_beat) r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[w_fill_idx][r_cnt] <= mem_rd_resp_data;
            if (w_last_beat) r_tag[w_fill_idx] <= w_fill_tag;
        end
        if (w_upd_we) r_data[w_req_idx][w_req_off] <= req_data;
    end

    assign out_valid        = w_out_vld;
    assign out_data         = w_out_vld ? r_data[w_req_idx][w_req_off] : '0;
    assign mem_rd_req_valid = w_rd_req_vld;
    assign mem_rd_req_addr  = w_rd_req_vld ? r_line : '0;

`ifdef D_CACHE_RESPONDER_WRITE_BUFFER_EN
    d_cache_responder_wbuf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wbuf (
        .clk           (clk),
        .rst           (rst),
        .i_push_vld    (w_push),
        .i_push_addr   (req_addr),
        .i_push_dat    (req_data),
        .i_mem_wr_rdy  (mem_wr_ready),
        .o_full        (w_wb_full),
        .o_mem_wr_vld  (mem_wr_valid),
        .o_mem_wr_addr (mem_wr_addr),
        .o_mem_wr_dat  (mem_wr_data)
    );
`else
    assign w_wb_full    = 1'b0;
    assign mem_wr_valid = w_wr_vld;
    assign mem_wr_addr  = w_wr_vld ? req_addr : '0;
    assign mem_wr_data  = w_wr_vld ? req_data : '0;
`endif

endmodule

// File: tb/tb_d_cache_responder.sv
// Directed bench for d_cache_responder: scoreboard of expected load data plus latency/traffic checks.
// Beat-based memory model reacts on the falling edge; monitor samples shortly after it.
module tb_d_cache_responder;
    import d_cache_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_mem_action;
    logic [25:0] req_addr;
    logic [31:0] req_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        mem_rd_req_valid, mem_rd_req_ready;
    logic [23:0] mem_rd_req_addr;
    logic        mem_rd_resp_valid;
    logic [31:0] mem_rd_resp_data;
    logic        mem_wr_valid, mem_wr_ready;
    logic [25:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    always #5 clk = ~clk;

    d_cache_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_mem_action(req_mem_action),
        .req_addr(req_addr), .req_data(req_data),
        .out_valid(out_valid), .out_data(out_data),
        .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_ready(mem_rd_req_ready),
        .mem_rd_req_addr(mem_rd_req_addr),
        .mem_rd_resp_valid(mem_rd_resp_valid), .mem_rd_resp_data(mem_rd_resp_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

`ifdef D_CACHE_RESPONDER_WRITE_BUFFER_EN
    localparam int WL0 = 0, WL3 = 0;
`else
    localparam int WL0 = 1, WL3 = 4;
`endif

    typedef struct {
        logic        is_read;
        logic [31:0] data;
        logic [25:0] addr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0, n_errors = 0;
    logic [31:0] mem [int];
    int          rd_cnt = 0, wr_cnt = 0, rd_phase = 0, beat = 0;
    int          rd_wait = 0, rd_delay = 0, wr_wait = 0, wr_delay = 0;
    bit          wr_active = 1'b0, seen = 1'b0;
    logic [23:0] rd_line = '0;
    logic [25:0] wr_addr_l = '0;
    logic [31:0] wr_data_l = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input int a);
        if (mem.exists(a)) return mem[a];
        return 32'hC000_0000 | 32'(a);
    endfunction

    // Memory model: refill beats and write acceptance, driven on the falling edge.
    initial begin
        mem_rd_req_ready = 0; mem_rd_resp_valid = 0; mem_rd_resp_data = 0; mem_wr_ready = 0;
        forever begin
            @(negedge clk);
            mem_rd_req_ready = 0; mem_rd_resp_valid = 0; mem_rd_resp_data = 0; mem_wr_ready = 0;
            if (rst) begin
                rd_phase = 0; beat = 0; rd_wait = 0; wr_wait = 0; wr_active = 0;
            end else begin
                if (rd_phase == 1) begin
                    mem_rd_resp_valid = 1;
                    mem_rd_resp_data  = rd_word(int'(rd_line) * 4 + beat);
                    beat++;
                    if (beat == 4) begin rd_phase = 0; beat = 0; end
                end else if (mem_rd_req_valid) begin
                    if (rd_wait < rd_delay) rd_wait++;
                    else begin
                        mem_rd_req_ready = 1;
                        rd_line = mem_rd_req_addr;
                        chk("rd_req_after_drain", {31'd0, mem_wr_valid}, 32'd0);
                        rd_cnt++; rd_phase = 1; beat = 0; rd_wait = 0;
                    end
                end
                if (mem_wr_valid) begin
                    if (!wr_active) begin
                        wr_active = 1; wr_addr_l = mem_wr_addr; wr_data_l = mem_wr_data;
                    end else begin
                        chk("wr_addr_stable", {6'd0, mem_wr_addr}, {6'd0, wr_addr_l});
                        chk("wr_data_stable", mem_wr_data, wr_data_l);
                    end
                    if (wr_wait < wr_delay) wr_wait++;
                    else begin
                        mem_wr_ready = 1;
                        mem[int'(mem_wr_addr)] = mem_wr_data;
                        wr_cnt++; wr_wait = 0; wr_active = 0;
                    end
                end
            end
        end
    end

    // Monitor: every completion pops one expectation; loads compare data.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 addr=%h, expected no completion", req_addr);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.is_read)
                        chk($sformatf("rd_data_%0h", mon_e.addr), out_data, mon_e.data);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the request completed.
    task automatic do_req(input logic act, input logic [25:0] a, input logic [31:0] d,
                          input int exp_lat, input logic [31:0] exp_d, input int exp_rd,
                          input logic [23:0] exp_line, input string nm);
        int   rd0, lat;
        exp_t e;
        rd0 = rd_cnt; lat = -1;
        e.is_read = (act == READ); e.data = exp_d; e.addr = a;
        sb.push_back(e);
        req_valid = 1; req_mem_action = act; req_addr = a; req_data = d;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #3;
            if (out_valid) begin lat = c; break; end
        end
        if (lat < 0) sb.delete();
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_rdreqs"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        if (exp_rd > 0) chk({nm, "_rdaddr"}, {8'd0, rd_line}, {8'd0, exp_line});
        @(posedge clk);
        #1;
        req_valid = 0; req_mem_action = 0; req_addr = 0; req_data = 0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (mem_wr_valid && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (mem_wr_valid) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: got mem_wr_valid=1, expected 0");
        end
    endtask

    task automatic op(input logic act, input logic [25:0] a, input logic [31:0] d,
                      input int exp_lat, input logic [31:0] exp_d, input int exp_rd,
                      input logic [23:0] exp_line, input string nm);
        drain();
        do_req(act, a, d, exp_lat, exp_d, exp_rd, exp_line, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        mem[32'h40] = 32'hA0; mem[32'h41] = 32'hA1; mem[32'h42] = 32'hA2; mem[32'h43] = 32'hA3;
        rst = 1; req_valid = 0; req_mem_action = 0; req_addr = 0; req_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rd_req_valid", {31'd0, mem_rd_req_valid}, 32'd0);
        chk("rst_wr_valid", {31'd0, mem_wr_valid}, 32'd0);
        chk("rst_outputs_zero", {8'd0, mem_rd_req_addr} | {6'd0, mem_wr_addr} | mem_wr_data | out_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 0;

        op(READ,  26'h40,  0,        6,   32'hA0, 1, 24'h10, "rd_miss_40");
        op(READ,  26'h42,  0,        0,   32'hA2, 0, 24'h0,  "rd_hit_42");
        wr_delay = 3;
        op(WRITE, 26'h41,  32'hDEAD, WL3, 32'h0,  0, 24'h0,  "wr_hit_41");
        op(READ,  26'h41,  0,        0,   32'hDEAD, 0, 24'h0, "rd_after_wr_41");
        wr_delay = 0;
        drain();
        chk("mem_41_written", rd_word(32'h41), 32'hDEAD);
        op(WRITE, 26'h800, 32'h5,    WL0, 32'h0,  0, 24'h0,  "wr_miss_800");
        op(READ,  26'h800, 0,        6,   32'h5,  1, 24'h200, "rd_800_noalloc");
        op(READ,  26'h40,  0,        0,   32'hA0, 0, 24'h0,  "rd_hit_40");
        rd_delay = 2;
        op(READ,  26'hC0,  0,        8,   32'hC00000C0, 1, 24'h30, "rd_conflict_c0");
        rd_delay = 0;
        op(READ,  26'h40,  0,        6,   32'hA0, 1, 24'h10, "rd_evicted_40");
        op(READ,  26'h41,  0,        0,   32'hDEAD, 0, 24'h0, "rd_hit_41");

        // Reset in the middle of a refill, after two beats.
        req_valid = 1; req_mem_action = READ; req_addr = 26'hC2; req_data = 0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (rd_phase == 1 && beat == 2) begin seen = 1; break; end
        end
        chk("midfill_reached", {31'd0, seen}, 32'd1);
        rst = 1; req_valid = 0; req_addr = 0;
        @(negedge clk);
        #2;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_rd_req_valid", {31'd0, mem_rd_req_valid}, 32'd0);
        chk("midrst_outputs_zero", {8'd0, mem_rd_req_addr} | {6'd0, mem_wr_addr} | out_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        #2;
        chk("postrst_idle_quiet", {30'd0, out_valid, mem_rd_req_valid}, 32'd0);
        @(posedge clk);
        #1;
        op(READ,  26'h40,  0,        6,   32'hA0, 1, 24'h10, "rd_after_rst_40");
        op(READ,  26'h43,  0,        0,   32'hA3, 0, 24'h0,  "rd_hit_43");

`ifdef D_CACHE_RESPONDER_WRITE_BUFFER_EN
        drain();
        wr_delay = 3;
        do_req(WRITE, 26'h61, 32'h1111, 0,  32'h0, 0, 24'h0, "wb_wr_first");
        do_req(WRITE, 26'h62, 32'h2222, 4,  32'h0, 0, 24'h0, "wb_wr_second");
        do_req(READ,  26'h4,  0,        10, 32'hC0000004, 1, 24'h1, "wb_rd_waits");
        wr_delay = 0;
        drain();
        chk("wb_mem_61", rd_word(32'h61), 32'h1111);
        chk("wb_mem_62", rd_word(32'h62), 32'h2222);
`endif

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/d_cache_responder.md
Name: d_cache_responder

Overview:
- Responder end of the data-cache request interface. The hazard controller and EX stage drive requests (valid, mem_action, addr, data) into this block; it returns cache output (valid, data) to MEM and to the value-prediction path.
- Direct-mapped, write-through, no-write-allocate data cache.
- Blocking: one outstanding miss at a time, refilled from a beat-based memory port.
- out_valid low means "miss in progress". The requester stalls or speculates while it is low.

Parameters:
- INDEX_WIDTH, 5, log2 of number of lines.
- BLOCK_OFFSET_WIDTH, 2, log2 of words per line (4 words).
- ADDR_WIDTH, 26, word address width (matches `ADDR_WIDTH).
- DATA_WIDTH, 32, word width (matches `DATA_WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present; requester holds all req_* stable until out_valid=1
- req_mem_action  in  1  0=READ, 1=WRITE
- req_addr  in  ADDR_WIDTH  word address
- req_data  in  DATA_WIDTH  store data
- out_valid  out  1  request completed this cycle (combinational in IDLE)
- out_data  out  DATA_WIDTH  load data; valid only when out_valid and READ
- mem_rd_req_valid  out  1  line refill request
- mem_rd_req_ready  in  1  memory accepts refill request
- mem_rd_req_addr  out  ADDR_WIDTH-BLOCK_OFFSET_WIDTH  line address
- mem_rd_resp_valid  in  1  one refill beat, word 0 first
- mem_rd_resp_data  in  DATA_WIDTH  beat data
- mem_wr_valid  out  1  write-through word
- mem_wr_ready  in  1  memory accepts write
- mem_wr_addr  out  ADDR_WIDTH  write word address
- mem_wr_data  out  DATA_WIDTH  write data

Behaviour:
- Address split: {tag, index, offset}. Tag width is ADDR_WIDTH-INDEX_WIDTH-BLOCK_OFFSET_WIDTH.
- Storage is flops: valid bit, tag and data words per line.
- Reset:
  - All valid bits cleared; state returns to IDLE; beat counter = 0.
  - out_valid = 0, mem_rd_req_valid = 0, mem_wr_valid = 0; address/data outputs = 0.
  - Reset mid-refill or mid-write abandons the operation. The memory model shares rst.
- FSM states: IDLE, RD_REQ, RD_FILL, WR.
- IDLE, READ hit (valid & tag match): out_valid = 1 in the same cycle; out_data = stored word. Zero added latency.
- IDLE, READ miss: out_valid = 0; latch line address; go to RD_REQ.
- RD_REQ: mem_rd_req_valid = 1 until the cycle mem_rd_req_ready = 1, then go to RD_FILL with beat counter = 0.
- RD_FILL:
  - Each mem_rd_resp_valid writes the beat into data[index][counter], then counter++.
  - On the last beat (counter = 2^BLOCK_OFFSET_WIDTH-1): write tag, set valid, counter wraps to 0, go to IDLE.
  - The next cycle hits. Minimum miss latency = 1 + 4 + 1 cycles.
- IDLE, WRITE: go to WR, out_valid = 0.
- WR:
  - mem_wr_valid = 1 with req_addr/req_data until mem_wr_ready.
  - In the handshake cycle: if the line is a hit, update the stored word; out_valid = 1; return to IDLE.
  - A write miss does not allocate.
- Back-to-back: a new request may be presented the cycle after out_valid. An unchanged request held one extra cycle re-executes; for a READ this is harmless.
- Requester changing req_* while out_valid = 0 is a protocol violation. The responder uses the latched line address and does not check.
- req_valid = 0 in IDLE: no action, out_valid = 0.

Optional Feature:
- Macro: D_CACHE_RESPONDER_WRITE_BUFFER_EN.
- Enabled:
  - A one-entry write buffer is added.
  - A WRITE in IDLE with the buffer empty completes in the same cycle (out_valid = 1) and updates the stored word on a hit.
  - The buffer drains via mem_wr_* in the background.
  - A WRITE arriving with the buffer full waits (out_valid = 0) until the drain completes.
  - A READ miss with the buffer full waits in IDLE until drained before entering RD_REQ, preserving ordering.
  - A READ hit is unaffected.
- Disabled: behaviour exactly as in Behaviour (WR state, blocking writes).

Decomposition:
- Shared package (mips_core_pkg): mem_action_t (READ/WRITE), d_cache_responder state enum, and tag/index/offset width localparams derived from the parameters.
- One natural sub-module: d_cache_responder_wbuf (optional write buffer, instantiated only under the macro).

Test Plan:
- Reset, then READ addr 0x40: out_valid = 0.
  - Expect mem_rd_req_addr = 0x10.
  - Supply 4 beats 0xA0..0xA3 → out_valid = 1, out_data = 0xA0 one cycle after the last beat.
- READ addr 0x42 after that fill → out_valid = 1 combinationally, out_data = 0xA2, no memory traffic.
- WRITE 0x41 data 0xDEAD, mem_wr_ready delayed 3 cycles:
  - mem_wr_* held stable.
  - out_valid only in the handshake cycle.
  - A subsequent READ 0x41 returns 0xDEAD.
- WRITE miss 0x800 data 5, then READ 0x800 → a refill occurs; the cache line is not allocated by the write.
- Conflict: READ 0x40, then READ 0x40 + (1<<7) (same index, different tag) → second refill. READ 0x40 again misses.
- Assert rst during RD_FILL after 2 beats → all outputs 0, state IDLE. READ 0x40 then misses and refills.
- Macro on:
  - Two WRITEs back-to-back with mem_wr_ready low: first completes in 0 cycles, second waits.
  - A READ miss waits for drain before mem_rd_req_valid rises.
